// File: rtl/rgb888_word_packer.sv
// rgb888_word_packer
// Packs RGB888 pixels densely (4 pixels -> 3 words) onto a 32-bit
// AXI4-Stream. It generates tuser on the first word of a frame and tlast on
// the last word of a line, and pads partial words at end of line with tkeep.
// Backpressure to the pixel core comes from the fill level of a small word FIFO.
// Optional feature: define RGB888_PACK_ERR_CNT_EN to add the saturating
// err_count output that counts misaligned sof pixels.
module rgb888_word_packer #(
   parameter int FIFO_DEPTH = 4,
   parameter int ERR_CNT_W  = 16
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   input  logic        valid,
   input  logic        sof,
   input  logic        eol,
   output logic        in_stream_ready,
   output logic [31:0] out_stream_tdata,
   output logic [3:0]  out_stream_tkeep,
   output logic        out_stream_tlast,
   output logic        out_stream_tvalid,
   input  logic        out_stream_tready,
   output logic        out_stream_tuser
`ifdef RGB888_PACK_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_count
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] TWO_L   = (AW+1)'(2);

   typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        user;
   } word_t;

   phase_e         phase_q, phase_d, ph_eff;
   logic [23:0]    res_q, res_d, res_eff;
   logic           pend_sof_q, pend_sof_d;
   logic           run_q;
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_p1;
   logic [AW:0]    count_q;
   word_t          mem [FIFO_DEPTH];
   word_t          head, w0, w1;
   logic [23:0]    px;
   logic [1:0]     n_push;
   logic           accept, pop, err_pulse;

   assign px        = {r, g, b};
   assign accept    = valid && in_stream_ready;
   assign pop       = out_stream_tvalid && out_stream_tready;
   assign wr_ptr_p1 = wr_ptr_q + AW'(1);

   // Next phase, residue and the 0..2 words produced by the accepted pixel.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      phase_d    = phase_q;
      res_d      = res_q;
      pend_sof_d = pend_sof_q;
      ph_eff     = phase_q;
      res_eff    = res_q;
      n_push     = 2'd0;
      w0         = '0;
      w1         = '0;
      err_pulse  = 1'b0;
      if (accept) begin
         // A sof pixel always starts a fresh word; leftover bytes are dropped.
         if (sof) begin
            ph_eff    = PH0;
            res_eff   = '0;
            err_pulse = (phase_q != PH0);
         end
         w0.user = pend_sof_q || sof;
         case (ph_eff)
            PH0: begin
               if (eol) begin
                  w0.data = {8'h00, px};
                  w0.keep = 4'b0111;
                  w0.last = 1'b1;
                  n_push  = 2'd1;
               end else begin
                  res_d   = px;
                  phase_d = PH1;
               end
            end
            PH1: begin
               w0.data = {px[7:0], res_eff};
               w0.keep = 4'hF;
               n_push  = 2'd1;
               if (eol) begin
                  w1.data = {16'h0000, px[23:8]};
                  w1.keep = 4'b0011;
                  w1.last = 1'b1;
                  n_push  = 2'd2;
               end else begin
                  res_d   = {8'h00, px[23:8]};
                  phase_d = PH2;
               end
            end
            PH2: begin
               w0.data = {px[15:0], res_eff[15:0]};
               w0.keep = 4'hF;
               n_push  = 2'd1;
               if (eol) begin
                  w1.data = {24'h000000, px[23:16]};
                  w1.keep = 4'b0001;
                  w1.last = 1'b1;
                  n_push  = 2'd2;
               end else begin
                  res_d   = {16'h0000, px[23:16]};
                  phase_d = PH3;
               end
            end
            PH3: begin
               w0.data = {px, res_eff[7:0]};
               w0.keep = 4'hF;
               w0.last = eol;
               n_push  = 2'd1;
               res_d   = '0;
               phase_d = PH0;
            end
         endcase
         if (eol) begin
            res_d   = '0;
            phase_d = PH0;
         end
         pend_sof_d = (n_push != 2'd0) ? 1'b0 : (pend_sof_q || sof);
      end
   end

   // Phase state register with residue and pending-sof flag.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         phase_q    <= PH0;
         res_q      <= '0;
         pend_sof_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         phase_q    <= phase_d;
         res_q      <= res_d;
         pend_sof_q <= pend_sof_d;
      end
   end

   // FIFO pointers, occupancy and the out-of-reset flag that enables ready.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         run_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         run_q    <= 1'b1;
         wr_ptr_q <= wr_ptr_q + AW'(n_push);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         count_q  <= count_q + (AW+1)'(n_push) - (AW+1)'(pop);
      end
   end

   // FIFO storage; one or two words written per accepted pixel.
   // NOTE: the storage array has no reset; contents are only observed when count marks them valid.
   always_ff @(posedge aclk) begin
      if (n_push != 2'd0) mem[wr_ptr_q]  <= w0;
      if (n_push == 2'd2) mem[wr_ptr_p1] <= w1;
   end

   assign head              = mem[rd_ptr_q];
   assign out_stream_tvalid = (count_q != '0);
   assign out_stream_tdata  = out_stream_tvalid ? head.data : 32'h0;
   assign out_stream_tkeep  = out_stream_tvalid ? head.keep : 4'h0;
   assign out_stream_tlast  = out_stream_tvalid && head.last;
   assign out_stream_tuser  = out_stream_tvalid && head.user;
   // Two free entries guarantee room for the worst-case pixel.
   assign in_stream_ready   = run_q && ((DEPTH_L - count_q) >= TWO_L);

`ifdef RGB888_PACK_ERR_CNT_EN
   // Saturating count of misaligned sof pixels, cleared only by reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                      err_count <= '0;
      else if (err_pulse && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
   end
`else
   logic unused_err;
   assign unused_err = err_pulse & (ERR_CNT_W != 0);
`endif

endmodule

// File: tb/tb_rgb888_word_packer.sv
// tb_rgb888_word_packer
// Directed table of pixels with their expected words, backpressure and reset
// sequences, and randomized lines checked against a byte-queue reference model.
module tb_rgb888_word_packer;

   localparam int DEPTH = 4;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [7:0]  r = '0, g = '0, b = '0;
   logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
   logic        in_stream_ready;
   logic [31:0] out_stream_tdata;
   logic [3:0]  out_stream_tkeep;
   logic        out_stream_tlast;
   logic        out_stream_tvalid;
   logic        out_stream_tready = 1'b1;
   logic        out_stream_tuser;
`ifdef RGB888_PACK_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   rgb888_word_packer #(.FIFO_DEPTH(DEPTH), .ERR_CNT_W(16)) dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .r                 (r),
      .g                 (g),
      .b                 (b),
      .valid             (valid),
      .sof               (sof),
      .eol               (eol),
      .in_stream_ready   (in_stream_ready),
      .out_stream_tdata  (out_stream_tdata),
      .out_stream_tkeep  (out_stream_tkeep),
      .out_stream_tlast  (out_stream_tlast),
      .out_stream_tvalid (out_stream_tvalid),
      .out_stream_tready (out_stream_tready),
      .out_stream_tuser  (out_stream_tuser)
`ifdef RGB888_PACK_ERR_CNT_EN
      ,
      .err_count         (err_count)
`endif
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        user;
   } exp_t;

   typedef struct {
      logic [23:0] px;
      logic        s;
      logic        e;
      int          n;
      exp_t        e0;
      exp_t        e1;
   } vec_t;

   int         n_vec = 0;
   int         n_err = 0;
   exp_t       exp_q[$];
   vec_t       tbl[$];
   logic [7:0] m_bytes[$];
   logic       m_sof_pend = 1'b0;
   int         m_err = 0;
   bit         use_model = 1'b0;
   int         tready_mode = 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   function automatic exp_t ew(logic [31:0] d, logic [3:0] k, logic l, logic u);
      return {d, k, l, u};
   endfunction

   function automatic void add(logic [23:0] p, logic s, logic e, int n, exp_t e0, exp_t e1);
      vec_t v;
      v.px = p; v.s = s; v.e = e; v.n = n; v.e0 = e0; v.e1 = e1;
      tbl.push_back(v);
   endfunction

   // Reference: a stream of little-endian bytes cut into 4-byte words.
   function automatic void model_accept(logic [23:0] p, logic s, logic e);
      exp_t w;
      int   n;
      if (s) begin
         if (m_bytes.size() != 0) m_err++;
         m_bytes.delete();
         m_sof_pend = 1'b1;
      end
      m_bytes.push_back(p[7:0]);
      m_bytes.push_back(p[15:8]);
      m_bytes.push_back(p[23:16]);
      while (m_bytes.size() >= 4 || (e && m_bytes.size() != 0)) begin
         w = '0;
         n = (m_bytes.size() >= 4) ? 4 : m_bytes.size();
         for (int i = 0; i < n; i++) w.data[8*i +: 8] = m_bytes.pop_front();
         w.keep = 4'((1 << n) - 1);
         w.last = e && (m_bytes.size() == 0);
         w.user = m_sof_pend;
         m_sof_pend = 1'b0;
         exp_q.push_back(w);
      end
   endfunction

   // Output monitor: sampled on the falling edge, away from the active edge.
   exp_t prev_w;
   bit   stalled = 1'b0;
   always @(negedge aclk) begin
      exp_t got, want;
      got = {out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser};
      if (!aresetn) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("hold_tvalid", 64'(out_stream_tvalid), 64'(1));
            check("hold_word", 64'(got), 64'(prev_w));
         end
         if (!out_stream_tvalid) begin
            check("idle_zero", 64'(got), 64'(0));
         end else if (out_stream_tready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_word: got %h, want no word", got);
            end else begin
               want = exp_q.pop_front();
               check("word", 64'(got), 64'(want));
            end
         end
         stalled = out_stream_tvalid && !out_stream_tready;
         prev_w  = got;
      end
   end

   // Random sink readiness when enabled.
   initial forever begin
      @(posedge aclk);
      #1;
      if (tready_mode == 2) out_stream_tready = 1'($urandom_range(0, 1));
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog expired");
   end

   // Present one pixel and hold it until accepted. Starts and ends 1 time unit after a rising edge.
   task automatic send_px(input logic [23:0] p, input logic s, input logic e, output bit ok);
      int waits;
      waits = 0;
      {r, g, b} = p;
      sof = s;
      eol = e;
      valid = 1'b1;
      check("in_ready", 64'(in_stream_ready), 64'((DEPTH - exp_q.size()) >= 2));
      while (!in_stream_ready && waits < 300) begin
         @(posedge aclk);
         #1;
         waits++;
         check("in_ready", 64'(in_stream_ready), 64'((DEPTH - exp_q.size()) >= 2));
      end
      ok = in_stream_ready;
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: pixel %h not accepted within %0d cycles", p, waits);
      end
      @(posedge aclk);
      #1;
      valid = 1'b0;
      sof = 1'b0;
      eol = 1'b0;
      if (ok && use_model) model_accept(p, s, e);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || out_stream_tvalid) && t < 500) begin
         @(posedge aclk);
         #1;
         t++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic send_line(input logic [23:0] base, input int len);
      bit ok;
      for (int i = 0; i < len; i++)
         send_px(base + 24'(i * 24'h030507), (i == 0), (i == len - 1), ok);
   endtask

   initial begin
      bit ok;
      int len, mis;
      bit fs;
      exp_t z;
      z = '0;

      // Directed vectors: pixel in, words expected from that pixel.
      add(24'h112233, 1, 0, 0, z, z);
      add(24'h445566, 0, 0, 1, ew(32'h66112233, 4'hF, 0, 1), z);
      add(24'h778899, 0, 0, 1, ew(32'h88994455, 4'hF, 0, 0), z);
      add(24'hAABBCC, 0, 1, 1, ew(32'hAABBCC77, 4'hF, 1, 0), z);
      add(24'h112233, 1, 0, 0, z, z);
      add(24'h445566, 0, 1, 2, ew(32'h66112233, 4'hF, 0, 1), ew(32'h00004455, 4'h3, 1, 0));
      add(24'hABCDEF, 1, 1, 1, ew(32'h00ABCDEF, 4'h7, 1, 1), z);
      add(24'h5A5A5A, 0, 0, 0, z, z);
      add(24'h010203, 1, 0, 0, z, z);
      add(24'h040506, 0, 0, 1, ew(32'h06010203, 4'hF, 0, 1), z);
      add(24'h070809, 0, 0, 1, ew(32'h08090405, 4'hF, 0, 0), z);
      add(24'h0A0B0C, 0, 1, 1, ew(32'h0A0B0C07, 4'hF, 1, 0), z);
      add(24'h111111, 0, 0, 0, z, z);
      add(24'h222222, 0, 0, 1, ew(32'h22111111, 4'hF, 0, 0), z);
      add(24'h010203, 1, 0, 0, z, z);
      add(24'h040506, 0, 0, 1, ew(32'h06010203, 4'hF, 0, 1), z);
      add(24'h070809, 0, 0, 1, ew(32'h08090405, 4'hF, 0, 0), z);
      add(24'h0A0B0C, 0, 1, 1, ew(32'h0A0B0C07, 4'hF, 1, 0), z);
      add(24'h111111, 1, 0, 0, z, z);
      add(24'h222222, 0, 0, 1, ew(32'h22111111, 4'hF, 0, 1), z);
      add(24'h333333, 0, 1, 2, ew(32'h33332222, 4'hF, 0, 0), ew(32'h00000033, 4'h1, 1, 0));
      add(24'h123456, 0, 1, 1, ew(32'h00123456, 4'h7, 1, 0), z);

      // Reset state.
      #1;
      check("rst_tvalid", 64'(out_stream_tvalid), 64'(0));
      check("rst_ready", 64'(in_stream_ready), 64'(0));
      check("rst_tdata", 64'(out_stream_tdata), 64'(0));
      check("rst_tkeep", 64'(out_stream_tkeep), 64'(0));
      check("rst_tlast_tuser", 64'({out_stream_tlast, out_stream_tuser}), 64'(0));
      #22 aresetn = 1'b1;
      @(posedge aclk);
      #1;
      check("ready_after_reset", 64'(in_stream_ready), 64'(1));

      // Table-driven directed vectors with tready=1.
      use_model = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         send_px(tbl[i].px, tbl[i].s, tbl[i].e, ok);
         if (ok && tbl[i].n >= 1) exp_q.push_back(tbl[i].e0);
         if (ok && tbl[i].n == 2) exp_q.push_back(tbl[i].e1);
      end
      drain();
`ifdef RGB888_PACK_ERR_CNT_EN
      check("err_count_table", 64'(err_count), 64'(2));
`endif

      // Same line unstalled, then with the sink stalled for 12 cycles.
      use_model = 1'b1;
      m_bytes.delete();
      m_sof_pend = 1'b0;
      send_line(24'h102030, 8);
      drain();
      tready_mode = 0;
      out_stream_tready = 1'b0;
      fork
         begin
            repeat (12) @(posedge aclk);
            #1;
            out_stream_tready = 1'b1;
            tready_mode = 1;
         end
      join_none
      send_line(24'h102030, 8);
      drain();

      // Asynchronous reset mid-line while a word is waiting.
      tready_mode = 0;
      out_stream_tready = 1'b0;
      send_px(24'h112233, 1, 0, ok);
      send_px(24'h445566, 0, 0, ok);
      send_px(24'h778899, 0, 0, ok);
      #2 aresetn = 1'b0;
      #1;
      check("midrst_tvalid", 64'(out_stream_tvalid), 64'(0));
      check("midrst_ready", 64'(in_stream_ready), 64'(0));
      check("midrst_tdata", 64'(out_stream_tdata), 64'(0));
      exp_q.delete();
      m_bytes.delete();
      m_sof_pend = 1'b0;
      m_err = 0;
`ifdef RGB888_PACK_ERR_CNT_EN
      check("midrst_err_count", 64'(err_count), 64'(0));
`endif
      @(posedge aclk);
      #3 aresetn = 1'b1;
      @(posedge aclk);
      #1;
      out_stream_tready = 1'b1;
      tready_mode = 1;
      send_px(24'hC0FFEE, 1, 0, ok);
      send_px(24'h445566, 0, 1, ok);
      drain();

      // Randomized lines, gaps, occasional misaligned sof, random sink ready.
      tready_mode = 2;
      for (int ln = 0; ln < 40; ln++) begin
         len = $urandom_range(1, 9);
         fs  = ($urandom_range(0, 2) == 0);
         mis = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : -1;
         for (int i = 0; i < len; i++) begin
            send_px(24'($urandom), (i == 0 && fs) || (i == mis), (i == len - 1), ok);
            repeat ($urandom_range(0, 2)) begin
               @(posedge aclk);
               #1;
            end
         end
      end
      tready_mode = 1;
      out_stream_tready = 1'b1;
      drain();
`ifdef RGB888_PACK_ERR_CNT_EN
      check("err_count_random", 64'(err_count), 64'(m_err));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
